led_pattern_gen: RTL

- Parametrised, multi-channel successor to the single fixed 1 Hz LED blinker.
- N_CH independent LED channels. Each has a runtime-programmable mode: off, on, blink with a programmable half-period, or PWM dim with a programmable duty.
- Sits in the FPGA top on sys_clk (100 MHz) and drives LED[] directly.
- Configured through a simple single-cycle register-write port; a global sync input re-phases all channels.

---
 rtl/led_pattern_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - multi-channel LED driver with off/on/blink/PWM modes
module led_pattern_gen #(
    parameter int N_CH     = 8,
    parameter int TICK_DIV = 100_000,
    parameter int PERIOD_W = 12,
    parameter int PWM_W    = 8,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_half,
    input  logic [PWM_W-1:0]    cfg_duty,
    input  logic                sync,
    output logic                tick,
    output logic [N_CH-1:0]     led
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } mode_e;

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [PWM_W-1:0]    pwm_q, pwm_d;
    mode_e               mode_q  [N_CH];
    mode_e               mode_d  [N_CH];
    logic [PERIOD_W-1:0] half_q  [N_CH];
    logic [PERIOD_W-1:0] half_d  [N_CH];
    logic [PWM_W-1:0]    duty_q  [N_CH];
    logic [PWM_W-1:0]    duty_d  [N_CH];
    logic [PERIOD_W-1:0] phase_q [N_CH];
    logic [PERIOD_W-1:0] phase_d [N_CH];
    logic [N_CH-1:0]     state_q, state_d;
    logic [N_CH-1:0]     led_q, led_d;
    logic                tick_evt;
    logic                cfg_hit;

    // Next-state: prescaler, shared PWM counter, per-channel config, blink phase and LED drive
    always_comb begin
        tick_evt = (presc_q == PRESC_LAST) && !sync;
        // Widen by one bit so out-of-range indices are detectable even when N_CH is a power of two
        cfg_hit  = cfg_we && ({1'b0, cfg_ch} < (CH_W + 1)'(N_CH));
        presc_d  = (sync || presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick_d   = tick_evt;
        pwm_d    = sync ? '0 : pwm_q + 1'b1;
        state_d  = state_q;
        led_d    = '0;
        for (int i = 0; i < N_CH; i++) begin
            mode_d[i]  = mode_q[i];
            half_d[i]  = half_q[i];
            duty_d[i]  = duty_q[i];
            phase_d[i] = phase_q[i];

            // A half-period of 0 behaves like 1, so the last phase is 0 in both cases
            if (sync) begin
                phase_d[i] = '0;
                state_d[i] = 1'b0;
            end else if (tick_evt && mode_q[i] == MODE_BLINK) begin
                if (phase_q[i] == ((half_q[i] == '0) ? '0 : half_q[i] - PERIOD_W'(1))) begin
                    phase_d[i] = '0;
                    state_d[i] = ~state_q[i];
                end else begin
                    phase_d[i] = phase_q[i] + 1'b1;
                end
            end

            // A write re-phases its channel and takes priority over a coincident tick
            if (cfg_hit && cfg_ch == CH_W'(i)) begin
                mode_d[i]  = mode_e'(cfg_mode);
                half_d[i]  = cfg_half;
                duty_d[i]  = cfg_duty;
                phase_d[i] = '0;
                state_d[i] = 1'b0;
            end

            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = state_q[i];
                MODE_PWM:   led_d[i] = (pwm_q < duty_q[i]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    // State registers with asynchronous clear of everything, including configuration
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            state_q <= '0;
            led_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i]  <= MODE_OFF;
                half_q[i]  <= '0;
                duty_q[i]  <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            state_q <= state_d;
            led_q   <= led_d;
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i]  <= mode_d[i];
                half_q[i]  <= half_d[i];
                duty_q[i]  <= duty_d[i];
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign tick = tick_q;
    assign led  = led_q;

endmodule
